// File: rtl/sys_array_loader.sv
// ---------------------------------------------------------------------------
// sys_array_loader
//
// Upstream feeder for the systolic-array fetcher. A serial stream of
// DATA_WIDTH-bit elements (valid/ready handshake) is assembled row-major into
// the weight matrix and then the input-data matrix. Once both are complete the
// block sequences the fetcher: one clear cycle, one weight-load pulse, one
// start pulse, then waits for the fetcher's result-valid level or a timeout.
//
// Ports
//   clk           : clock, everything on the rising edge
//   reset_n       : synchronous active-low reset
//   in_data       : stream element
//   in_valid      : in_data is valid
//   in_ready      : loader accepts an element this cycle
//   weights_out   : weight matrix  [row][col], to fetcher input_data_w
//   data_out      : data matrix    [row][col], to fetcher input_data_b
//   fetch_reset_n : fetcher reset, low while reset_n is low and for the CLR cycle
//   load_params   : one-cycle weight-load pulse
//   start_comp    : one-cycle start pulse
//   comp_ready    : fetcher result-valid level
//   busy          : high from CLR through WAIT
//   done          : one-cycle pulse when a run ends (success or timeout)
//   timeout_err   : sticky timeout flag, cleared only by reset_n
// ---------------------------------------------------------------------------
module sys_array_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_W_W  = 2,
    parameter int ARRAY_W_L  = 5,
    parameter int ARRAY_A_W  = 5,
    parameter int ARRAY_A_L  = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] weights_out,
    output logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] data_out,
    output logic                  fetch_reset_n,
    output logic                  load_params,
    output logic                  start_comp,
    input  logic                  comp_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    // -----------------------------------------------------------------------
    // Derived sizes
    // -----------------------------------------------------------------------
    localparam int NW   = ARRAY_W_W * ARRAY_W_L;
    localparam int NA   = ARRAY_A_W * ARRAY_A_L;
    localparam int NMAX = (NW > NA) ? NW : NA;
    localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1;

    // Shared row/column counters are sized for the larger of the two matrices;
    // each matrix write uses only the low bits it needs.
    localparam int RMAX = (ARRAY_W_W > ARRAY_A_W) ? ARRAY_W_W : ARRAY_A_W;
    localparam int CMAX = (ARRAY_W_L > ARRAY_A_L) ? ARRAY_W_L : ARRAY_A_L;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int WRW  = (ARRAY_W_W > 1) ? $clog2(ARRAY_W_W) : 1;
    localparam int WCW  = (ARRAY_W_L > 1) ? $clog2(ARRAY_W_L) : 1;
    localparam int ARW  = (ARRAY_A_W > 1) ? $clog2(ARRAY_A_W) : 1;
    localparam int ACW  = (ARRAY_A_L > 1) ? $clog2(ARRAY_A_L) : 1;

    localparam int TW   = $clog2(TIMEOUT);

    localparam logic [IW-1:0] W_IDX_LAST = IW'(NW - 1);
    localparam logic [IW-1:0] A_IDX_LAST = IW'(NA - 1);
    localparam logic [CW-1:0] W_COL_LAST = CW'(ARRAY_W_L - 1);
    localparam logic [CW-1:0] A_COL_LAST = CW'(ARRAY_A_L - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RECV_W = 3'd0,
        S_RECV_A = 3'd1,
        S_CLR    = 3'd2,
        S_LOAD   = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [TW-1:0]   wait_q;

    // Outputs are registered alongside the state: each one is loaded with the
    // value belonging to the state being entered, so it lines up with that
    // state and never depends combinationally on an input.
    logic            in_ready_q;
    logic            load_q;
    logic            start_q;
    logic            busy_q;
    logic            done_q;
    logic            timeout_q;

    logic [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0] weights_q;
    logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] data_q;

    logic            beat;

    // in_ready_q is only ever high in RECV_W/RECV_A, so this is the handshake
    assign beat = in_valid & in_ready_q;

    // -----------------------------------------------------------------------
    // FSM, counters, matrix capture and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_RECV_W;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wait_q     <= '0;
            in_ready_q <= 1'b0;
            load_q     <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            weights_q  <= '0;
            data_q     <= '0;
        end else begin
            // single-cycle pulses default low
            load_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;

            case (state_q)
                S_RECV_W: begin
                    in_ready_q <= 1'b1;
                    if (beat) begin
                        weights_q[row_q[WRW-1:0]][col_q[WCW-1:0]] <= in_data;
                        if (idx_q == W_IDX_LAST) begin
                            // weight matrix complete; data matrix starts at [0][0]
                            idx_q   <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                            state_q <= S_RECV_A;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            if (col_q == W_COL_LAST) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                    end
                end

                S_RECV_A: begin
                    in_ready_q <= 1'b1;
                    if (beat) begin
                        data_q[row_q[ARW-1:0]][col_q[ACW-1:0]] <= in_data;
                        if (idx_q == A_IDX_LAST) begin
                            idx_q      <= '0;
                            row_q      <= '0;
                            col_q      <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= S_CLR;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            if (col_q == A_COL_LAST) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end
                    end
                end

                // fetch_reset_n is low during this state (decoded below)
                S_CLR: begin
                    load_q  <= 1'b1;
                    state_q <= S_LOAD;
                end

                S_LOAD: begin
                    start_q <= 1'b1;
                    state_q <= S_START;
                end

                S_START: begin
                    wait_q  <= '0;
                    state_q <= S_WAIT;
                end

                // wait_q counts WAIT cycles from 0; the cycle that sees
                // WAIT_LAST is the TIMEOUT-th one. comp_ready wins a tie.
                S_WAIT: begin
                    if (comp_ready) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else if (wait_q == WAIT_LAST) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end

                S_DONE: begin
                    in_ready_q <= 1'b1;
                    state_q    <= S_RECV_W;
                end

                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    idx_q      <= '0;
                    row_q      <= '0;
                    col_q      <= '0;
                    state_q    <= S_RECV_W;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output mapping
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_W_W; gi++) begin : g_w_row
            assign weights_out[gi] = weights_q[gi];
        end
        for (gi = 0; gi < ARRAY_A_W; gi++) begin : g_a_row
            assign data_out[gi] = data_q[gi];
        end
    endgenerate

    assign in_ready      = in_ready_q;
    assign load_params   = load_q;
    assign start_comp    = start_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout_err   = timeout_q;

    // The only output that follows an input directly: the fetcher must see
    // reset as soon as reset_n drops, not one cycle later.
    assign fetch_reset_n = reset_n & (state_q != S_CLR);

endmodule

// File: tb/tb_sys_array_loader.sv
module tb_sys_array_loader;

    localparam int DW  = 8;
    localparam int WW  = 2;
    localparam int WL  = 5;
    localparam int AW  = 5;
    localparam int AL  = 2;
    localparam int TMO = 64;

    logic clk;
    logic reset_n;
    logic [DW-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic [0:WW-1][0:WL-1][DW-1:0] weights_out;
    logic [0:AW-1][0:AL-1][DW-1:0] data_out;
    logic fetch_reset_n;
    logic load_params;
    logic start_comp;
    logic comp_ready;
    logic busy;
    logic done;
    logic timeout_err;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int frn_cnt  = 0;

    sys_array_loader #(
        .DATA_WIDTH(DW), .ARRAY_W_W(WW), .ARRAY_W_L(WL),
        .ARRAY_A_W(AW), .ARRAY_A_L(AL), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .weights_out(weights_out), .data_out(data_out),
        .fetch_reset_n(fetch_reset_n), .load_params(load_params),
        .start_comp(start_comp), .comp_ready(comp_ready),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (reset_n && !fetch_reset_n) frn_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push nbeats elements base, base+1, ... ; with toggle, in_valid alternates 1/0.
    // Returns in the cycle after the last accepted beat.
    task automatic send_stream(input int base, input int nbeats, input bit toggle,
                               input int exp_cycles);
        int n = 0;
        int c = 0;
        bit v = 1'b1;
        bit beat_now;
        while (n < nbeats && c < 200) begin
            in_valid = toggle ? v : 1'b1;
            in_data  = DW'(base + n);
            beat_now = in_valid && in_ready;
            step();
            c++;
            if (beat_now) n++;
            v = ~v;
        end
        in_valid = 1'b0;
        chk("stream_beats", n, nbeats);
        chk("stream_cycles", c, exp_cycles);
        $display("stream base=%0d beats=%0d cycles=%0d toggle=%0d", base, n, c, toggle);
    endtask

    task automatic check_mats(input int base);
        for (int r = 0; r < WW; r++)
            for (int c = 0; c < WL; c++)
                chk($sformatf("w[%0d][%0d]", r, c), 32'(weights_out[r][c]), base + WL*r + c);
        for (int r = 0; r < AW; r++)
            for (int c = 0; c < AL; c++)
                chk($sformatf("a[%0d][%0d]", r, c), 32'(data_out[r][c]), base + WW*WL + AL*r + c);
    endtask

    // Entered in cycle T+1 (right after the last beat); leaves in T+4, first WAIT cycle.
    task automatic seq_check();
        int frn0 = frn_cnt;
        chk("clr_frn",   fetch_reset_n, 0);
        chk("clr_busy",  busy, 1);
        chk("clr_rdy",   in_ready, 0);
        chk("clr_load",  load_params, 0);
        step();
        chk("load_pulse", load_params, 1);
        chk("load_frn",   fetch_reset_n, 1);
        chk("load_start", start_comp, 0);
        step();
        chk("start_pulse", start_comp, 1);
        chk("start_load",  load_params, 0);
        step();
        chk("wait_start", start_comp, 0);
        chk("wait_busy",  busy, 1);
        chk("frn_once",   frn_cnt - frn0, 1);
    endtask

    // From the first WAIT cycle: k more cycles without comp_ready, then raise it.
    task automatic run_ready(input int k);
        int d0 = done_cnt;
        comp_ready = 1'b0;
        for (int i = 0; i < k; i++) begin
            chk("wait_no_done", done, 0);
            step();
        end
        comp_ready = 1'b1;
        step();
        chk("done_pulse", done, 1);
        chk("done_busy",  busy, 0);
        comp_ready = 1'b0;
        step();
        chk("done_end",   done, 0);
        chk("post_rdy",   in_ready, 1);
        chk("post_busy",  busy, 0);
        chk("done_once",  done_cnt - d0, 1);
        $display("run ready after %0d wait cycles, timeout_err=%0d", k, timeout_err);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_w0"},   weights_out == '0, 1);
        chk({tag, "_a0"},   data_out == '0, 1);
        chk({tag, "_rdy"},  in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_tmo"},  timeout_err, 0);
        chk({tag, "_ld"},   load_params, 0);
        chk({tag, "_st"},   start_comp, 0);
        chk({tag, "_frn"},  fetch_reset_n, 0);
    endtask

    initial begin
        int c;
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        comp_ready = 1'b0;
        step();
        step();
        check_reset_vals("rst");

        reset_n = 1'b1;
        step();
        chk("rdy_after_rst", in_ready, 1);
        chk("idle_frn", fetch_reset_n, 1);

        // run 1: 1..20 back to back, comp_ready 14 cycles after start_comp
        send_stream(1, 20, 1'b0, 20);
        check_mats(1);
        seq_check();
        run_ready(13);

        // run 2: toggling valid, same values, then timeout
        send_stream(1, 20, 1'b1, 39);
        check_mats(1);
        seq_check();
        chk("tmo_pre", timeout_err, 0);
        c = 0;
        while (!done && c < 200) begin
            step();
            c++;
        end
        chk("tmo_cycles", c, TMO);
        chk("tmo_flag", timeout_err, 1);
        $display("run timed out after %0d wait cycles", c);
        step();
        chk("tmo_rdy", in_ready, 1);

        // run 3: success with sticky flag still set
        send_stream(30, 20, 1'b0, 20);
        check_mats(30);
        seq_check();
        run_ready(2);
        chk("tmo_sticky", timeout_err, 1);

        // run 4: reset while in WAIT
        send_stream(40, 20, 1'b0, 20);
        seq_check();
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("frn_follows_rst", fetch_reset_n, 0);
        step();
        check_reset_vals("rst_wait");
        reset_n = 1'b1;
        step();
        chk("rdy_after_rst2", in_ready, 1);

        // partial stream: 10 weights + 7 data beats, then reset in RECV_A
        send_stream(60, 17, 1'b0, 17);
        chk("part_w00", 32'(weights_out[0][0]), 60);
        chk("part_rdy", in_ready, 1);
        reset_n = 1'b0;
        step();
        check_reset_vals("rst_recv");
        reset_n = 1'b1;
        step();

        // two consecutive runs
        send_stream(1, 20, 1'b0, 20);
        check_mats(1);
        seq_check();
        run_ready(5);
        send_stream(100, 20, 1'b0, 20);
        chk("w00_100", 32'(weights_out[0][0]), 100);
        check_mats(100);
        seq_check();
        run_ready(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sys_array_loader.md
# sys_array_loader

Upstream feeder for the systolic-array fetcher. Accepts a serial stream of DATA_WIDTH-bit elements over a valid/ready handshake and assembles them into the weight matrix and the input-data matrix. It then sequences the fetcher: clear, load weights, start computation, and wait for completion or timeout. Its outputs connect directly to the fetcher's `input_data_w`, `input_data_b`, `load_params`, `start_comp` and reset inputs; the fetcher's `ready` returns as `comp_ready`.

## Interface
- DATA_WIDTH, 8, element width
- ARRAY_W_W, 2, weight-matrix rows
- ARRAY_W_L, 5, weight-matrix columns
- ARRAY_A_W, 5, data-matrix rows
- ARRAY_A_L, 2, data-matrix columns
- TIMEOUT, 64, maximum WAIT cycles before abort (≥2)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- in_data  in  DATA_WIDTH  stream element
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts element this cycle
- weights_out  out  [0:ARRAY_W_W-1][0:ARRAY_W_L-1][DATA_WIDTH-1:0]  to fetcher input_data_w
- data_out  out  [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]  to fetcher input_data_b
- fetch_reset_n  out  1  to fetcher reset_n; equals reset_n except low for the CLR cycle
- load_params  out  1  one-cycle weight-load pulse
- start_comp  out  1  one-cycle start pulse
- comp_ready  in  1  fetcher result-valid level
- busy  out  1  high in CLR, LOAD, START, WAIT
- done  out  1  one-cycle pulse when a run ends
- timeout_err  out  1  sticky; set on WAIT timeout

## Operation
- Beat = in_valid & in_ready. Elements arrive row-major: the first NW = ARRAY_W_W*ARRAY_W_L beats fill weights_out[r][c]; the next NA = ARRAY_A_W*ARRAY_A_L beats fill data_out[r][c].
- Element index counter: clog2(max(NW,NA)) bits, plus row/column counters or equivalent. Wraps to 0 at each matrix boundary.
- States:
  - RECV_W: in_ready=1. The beat at index NW-1 goes to RECV_A.
  - RECV_A: in_ready=1. The beat at index NA-1 goes to CLR.
  - CLR: fetch_reset_n=0 for 1 cycle (clears the fetcher's sticky ready). Then LOAD.
  - LOAD: load_params=1 for 1 cycle. Then START.
  - START: start_comp=1 for 1 cycle; WAIT counter cleared. Then WAIT.
  - WAIT: counter increments each cycle.
    - comp_ready=1 → DONE.
    - Counter reaches TIMEOUT-1 without comp_ready → set timeout_err, go to DONE.
    - comp_ready has priority if both occur in the same cycle.
  - DONE: done=1 for 1 cycle. Then RECV_W.
- in_ready=0 in all states other than RECV_W and RECV_A. in_valid outside those states is ignored; no data is dropped because no beat occurs.
- Matrix registers change only on beats. They hold their values through CLR..DONE and into the next run until overwritten. Partially received matrices keep their old values in the positions not yet written.
- timeout_err clears only on reset_n=0.
- Reset (reset_n=0 at any point, including mid-run) resets the outputs as follows:
  - state → RECV_W, all counters 0.
  - weights_out=0, data_out=0.
  - load_params=0, start_comp=0, done=0, busy=0, timeout_err=0.
  - in_ready=0 while reset_n=0.
  - fetch_reset_n=0 while reset_n=0.

## Timing
- All outputs except fetch_reset_n are decoded from registered state only; there is no combinational input→output path.
- fetch_reset_n = reset_n & (state != CLR).
- Last data beat at cycle T:
  - CLR at T+1
  - load_params at T+2
  - start_comp at T+3
  - WAIT from T+4
- comp_ready first seen high at cycle T+4+k → done at T+5+k, in_ready=1 at T+6+k.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then done=1 with timeout_err=1 on the same cycle.
- Throughput: 1 element per cycle while in RECV_W/RECV_A with in_valid held high. With defaults, 20 beats fill both matrices.

## Test plan
- Reset release, in_valid=1, elements 1..10 then 11..20 back-to-back:
  - weights_out[0][0..4]=1..5, weights_out[1][0..4]=6..10.
  - data_out[r][c]=11+2r+c.
  - CLR/LOAD/START on cycles T+1/T+2/T+3.
- comp_ready driven high 14 cycles after start_comp → done pulses exactly once, 1 cycle later; busy=0 and in_ready=1 the following cycle.
- comp_ready held 0 with TIMEOUT=64 → done after exactly 64 WAIT cycles, timeout_err=1 and remaining set through a second successful run until reset.
- in_valid toggling 1/0 every cycle during reception → only beats counted; 40 cycles to fill; values identical to scenario 1.
- reset_n=0 for 1 cycle in WAIT, then in RECV_A after 7 data beats:
  - everything returns to reset values.
  - next stream restarts at weights_out[0][0].
- Two consecutive runs (second stream 100..119) → fetch_reset_n low exactly 1 cycle per run; second done on comp_ready; weights_out[0][0]=100.
